// File: rtl/ex_stage_pipe_pkg.sv
// Shared types and constants for the EX stage: widths, ALU opcodes,
// control-bundle bit positions and the two pipeline-register layouts.
package ex_stage_pipe_pkg;

   localparam int DATA_W    = 32;
   localparam int RD_W      = 6;
   localparam int OP_W      = 4;
   localparam int ID_CTL_W  = 10;
   localparam int MEM_CTL_W = 7;

   typedef enum logic [OP_W-1:0] {
      NOP     = 4'd0,
      MAX     = 4'd1,
      UNUSED  = 4'd2,
      STORE   = 4'd3,
      ADD     = 4'd4,
      INC     = 4'd5,
      NEG     = 4'd6,
      SUB     = 4'd7,
      J       = 4'd8,
      BRZ     = 4'd9,
      JM      = 4'd10,
      BRN     = 4'd11,
      UNUSED1 = 4'd12,
      UNUSED2 = 4'd13,
      LOAD    = 4'd14,
      SAVE_PC = 4'd15
   } opcode_t;

   // id_ctl_in: {reg_wr,mem_to_reg,pc_to_reg,mem_read,mem_wr,branch_neg,branch_zero,jump,jump_mem,compute_max}
   localparam int ID_REG_WR      = 9;
   localparam int ID_MEM_TO_REG  = 8;
   localparam int ID_PC_TO_REG   = 7;
   localparam int ID_MEM_READ    = 6;
   localparam int ID_MEM_WR      = 5;
   localparam int ID_BRANCH_NEG  = 4;
   localparam int ID_BRANCH_ZERO = 3;
   localparam int ID_JUMP        = 2;
   localparam int ID_JUMP_MEM    = 1;
   localparam int ID_COMPUTE_MAX = 0;

   typedef struct packed {
      logic [ID_CTL_W-1:0] ctl;
      opcode_t             op;
      logic [DATA_W-1:0]   rs;
      logic [DATA_W-1:0]   rt;
      logic [RD_W-1:0]     rd;
      logic [DATA_W-1:0]   offset;
   } id_ex_t;

   typedef struct packed {
      logic [MEM_CTL_W-1:0] ctl;
      logic                 z;
      logic                 n;
      logic [DATA_W-1:0]    alu_result;
      logic [DATA_W-1:0]    dmem_dout;
      logic [DATA_W-1:0]    rs;
      logic [DATA_W-1:0]    offset;
      logic [RD_W-1:0]      rd;
   } ex_mem_t;

   // mem_ctl_out ordering: {reg_wr,pc_to_reg,branch_neg,branch_zero,jump,mem_to_reg,jump_mem}
   function automatic logic [MEM_CTL_W-1:0] mem_ctl_of(input logic [ID_CTL_W-1:0] c);
      return {c[ID_REG_WR], c[ID_PC_TO_REG], c[ID_BRANCH_NEG], c[ID_BRANCH_ZERO],
              c[ID_JUMP], c[ID_MEM_TO_REG], c[ID_JUMP_MEM]};
   endfunction

endpackage

// File: rtl/ex_stage_pipe_if.sv
// Decode-side inputs and EX/MEM-side outputs of the EX stage, bundled as one interface.
interface ex_stage_pipe_if
   import ex_stage_pipe_pkg::*;
   ();

   logic [ID_CTL_W-1:0]  id_ctl_in;
   logic [OP_W-1:0]      id_alu_op_in;
   logic [DATA_W-1:0]    id_rs_in;
   logic [DATA_W-1:0]    id_rt_in;
   logic [RD_W-1:0]      id_rd_in;
   logic [DATA_W-1:0]    id_offset_in;
   logic [DATA_W-1:0]    ex_dmem_dout;

   logic [DATA_W-1:0]    ex_rs;
   logic [DATA_W-1:0]    ex_rt;
   logic                 ex_mem_read;
   logic                 ex_mem_wr;
   logic                 ex_compute_max;
   logic [OP_W-1:0]      ex_alu_op;
   logic [DATA_W-1:0]    ex_alu_result;
   logic                 ex_z;
   logic                 ex_n;

   logic [MEM_CTL_W-1:0] mem_ctl_out;
   logic                 mem_z;
   logic                 mem_n;
   logic [DATA_W-1:0]    mem_alu_result;
   logic [DATA_W-1:0]    mem_dmem_dout;
   logic [DATA_W-1:0]    mem_rs;
   logic [DATA_W-1:0]    mem_offset;
   logic [RD_W-1:0]      mem_rd;

   modport master (
      output id_ctl_in, id_alu_op_in, id_rs_in, id_rt_in, id_rd_in, id_offset_in, ex_dmem_dout,
      input  ex_rs, ex_rt, ex_mem_read, ex_mem_wr, ex_compute_max, ex_alu_op,
             ex_alu_result, ex_z, ex_n,
             mem_ctl_out, mem_z, mem_n, mem_alu_result, mem_dmem_dout, mem_rs,
             mem_offset, mem_rd
   );

   modport slave (
      input  id_ctl_in, id_alu_op_in, id_rs_in, id_rt_in, id_rd_in, id_offset_in, ex_dmem_dout,
      output ex_rs, ex_rt, ex_mem_read, ex_mem_wr, ex_compute_max, ex_alu_op,
             ex_alu_result, ex_z, ex_n,
             mem_ctl_out, mem_z, mem_n, mem_alu_result, mem_dmem_dout, mem_rs,
             mem_offset, mem_rd
   );

endinterface

// File: rtl/ex_alu.sv
// Combinational EX-stage ALU: result plus zero/negative flags, arithmetic mod 2^DATA_W.
module ex_alu
   import ex_stage_pipe_pkg::*;
(
   input  opcode_t           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              z,
   output logic              n
);

   always_comb begin
      result = '0;
      case (op)
         ADD:     result = a + b;
         INC:     result = a + DATA_W'(1);
         NEG:     result = '0 - a;
         SUB:     result = a - b;
         default: result = '0;
      endcase
      z = (result == '0);
      n = result[DATA_W-1];
   end

endmodule

// File: rtl/ex_stage_pipe.sv
// ID/EX register, EX ALU and EX/MEM register. Both registers load every cycle;
// a low reset at a clock edge turns the whole pipe into a NOP bubble.
module ex_stage_pipe
   import ex_stage_pipe_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   ex_stage_pipe_if.slave bus
);

   id_ex_t            id_ex_d, id_ex_q;
   ex_mem_t           ex_mem_d, ex_mem_q;
   logic [DATA_W-1:0] alu_result;
   logic              alu_z;
   logic              alu_n;

   always_comb begin
      id_ex_d.ctl    = bus.id_ctl_in;
      id_ex_d.op     = opcode_t'(bus.id_alu_op_in);
      id_ex_d.rs     = bus.id_rs_in;
      id_ex_d.rt     = bus.id_rt_in;
      id_ex_d.rd     = bus.id_rd_in;
      id_ex_d.offset = bus.id_offset_in;
   end

   ex_alu u_alu (
      .op     (id_ex_q.op),
      .a      (id_ex_q.rs),
      .b      (id_ex_q.rt),
      .result (alu_result),
      .z      (alu_z),
      .n      (alu_n)
   );

   always_comb begin
      ex_mem_d.ctl        = mem_ctl_of(id_ex_q.ctl);
      ex_mem_d.z          = alu_z;
      ex_mem_d.n          = alu_n;
      ex_mem_d.alu_result = alu_result;
      ex_mem_d.dmem_dout  = bus.ex_dmem_dout;
      ex_mem_d.rs         = id_ex_q.rs;
      ex_mem_d.offset     = id_ex_q.offset;
      ex_mem_d.rd         = id_ex_q.rd;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         id_ex_q  <= '0;
         ex_mem_q <= '0;
      end else begin
         id_ex_q  <= id_ex_d;
         ex_mem_q <= ex_mem_d;
      end
   end

   assign bus.ex_rs          = id_ex_q.rs;
   assign bus.ex_rt          = id_ex_q.rt;
   assign bus.ex_mem_read    = id_ex_q.ctl[ID_MEM_READ];
   assign bus.ex_mem_wr      = id_ex_q.ctl[ID_MEM_WR];
   assign bus.ex_compute_max = id_ex_q.ctl[ID_COMPUTE_MAX];
   assign bus.ex_alu_op      = id_ex_q.op;
   assign bus.ex_alu_result  = alu_result;
   assign bus.ex_z           = alu_z;
   assign bus.ex_n           = alu_n;

   assign bus.mem_ctl_out    = ex_mem_q.ctl;
   assign bus.mem_z          = ex_mem_q.z;
   assign bus.mem_n          = ex_mem_q.n;
   assign bus.mem_alu_result = ex_mem_q.alu_result;
   assign bus.mem_dmem_dout  = ex_mem_q.dmem_dout;
   assign bus.mem_rs         = ex_mem_q.rs;
   assign bus.mem_offset     = ex_mem_q.offset;
   assign bus.mem_rd         = ex_mem_q.rd;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed + random bench for ex_stage_pipe with an EX/MEM expectation scoreboard.
module tb_ex_stage_pipe;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ex_stage_pipe_if bus ();

   ex_stage_pipe dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [9:0]  ctl;
      logic [3:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] off;
      logic [31:0] dmem;
      logic [31:0] res;
      logic [5:0]  rd;
      logic        z;
      logic        n;
   } exp_t;

   exp_t ex_q[$];
   exp_t mem_q[$];
   exp_t cur_ex;
   int   checks   = 0;
   int   failures = 0;

   function automatic exp_t mk(input logic [9:0] ctl, input logic [3:0] op,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [31:0] off, input logic [5:0] rd);
      exp_t e;
      e.ctl = ctl; e.op = op; e.rs = rs; e.rt = rt; e.off = off; e.rd = rd; e.dmem = 32'h0;
      case (op)
         4'd4:    e.res = rs + rt;
         4'd5:    e.res = rs + 32'd1;
         4'd6:    e.res = ~rs + 32'd1;
         4'd7:    e.res = rs + ~rt + 32'd1;
         default: e.res = 32'h0;
      endcase
      e.z = (e.res == 32'h0);
      e.n = e.res[31];
      return e;
   endfunction

   function automatic exp_t zero_mem();
      exp_t e;
      e = mk(10'h0, 4'd0, 32'h0, 32'h0, 32'h0, 6'h0);
      e.z = 1'b0;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic step(input logic rst_n, input logic [9:0] ctl, input logic [3:0] op,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] off,
                       input logic [5:0] rd, input logic [31:0] dmem);
      exp_t nx, mx, ge, gm;
      reset            = rst_n;
      bus.id_ctl_in    = ctl;
      bus.id_alu_op_in = op;
      bus.id_rs_in     = rs;
      bus.id_rt_in     = rt;
      bus.id_offset_in = off;
      bus.id_rd_in     = rd;
      bus.ex_dmem_dout = dmem;
      if (rst_n) begin
         nx = mk(ctl, op, rs, rt, off, rd);
         mx = cur_ex;
         mx.dmem = dmem;
      end else begin
         nx = mk(10'h0, 4'd0, 32'h0, 32'h0, 32'h0, 6'h0);
         mx = zero_mem();
      end
      ex_q.push_back(nx);
      mem_q.push_back(mx);
      @(posedge clk);
      @(negedge clk);
      ge = ex_q.pop_front();
      gm = mem_q.pop_front();
      cur_ex = ge;
      chk("ex_rs",          bus.ex_rs, ge.rs);
      chk("ex_rt",          bus.ex_rt, ge.rt);
      chk("ex_mem_read",    32'(bus.ex_mem_read), 32'(ge.ctl[6]));
      chk("ex_mem_wr",      32'(bus.ex_mem_wr), 32'(ge.ctl[5]));
      chk("ex_compute_max", 32'(bus.ex_compute_max), 32'(ge.ctl[0]));
      chk("ex_alu_op",      32'(bus.ex_alu_op), 32'(ge.op));
      chk("ex_alu_result",  bus.ex_alu_result, ge.res);
      chk("ex_z",           32'(bus.ex_z), 32'(ge.z));
      chk("ex_n",           32'(bus.ex_n), 32'(ge.n));
      chk("mem_ctl_out",    32'(bus.mem_ctl_out),
          32'({gm.ctl[9], gm.ctl[7], gm.ctl[4], gm.ctl[3], gm.ctl[2], gm.ctl[8], gm.ctl[1]}));
      chk("mem_z",          32'(bus.mem_z), 32'(gm.z));
      chk("mem_n",          32'(bus.mem_n), 32'(gm.n));
      chk("mem_alu_result", bus.mem_alu_result, gm.res);
      chk("mem_dmem_dout",  bus.mem_dmem_dout, gm.dmem);
      chk("mem_rs",         bus.mem_rs, gm.rs);
      chk("mem_offset",     bus.mem_offset, gm.off);
      chk("mem_rd",         32'(bus.mem_rd), 32'(gm.rd));
   endtask

   task automatic rnd_step(input logic rst_n);
      step(rst_n, 10'($urandom), 4'($urandom), $urandom, $urandom, $urandom,
           6'($urandom), $urandom);
   endtask

   initial begin
      cur_ex = mk(10'h0, 4'd0, 32'h0, 32'h0, 32'h0, 6'h0);
      reset  = 1'b0;

      rnd_step(1'b0);
      rnd_step(1'b0);

      // ADD, SUB, LOAD back to back, then SUB to zero and negative
      step(1'b1, 10'h200, 4'd4,  32'd5, 32'd7, 32'h0,   6'd3,  32'h0);
      step(1'b1, 10'h200, 4'd7,  32'd9, 32'd9, 32'h4,   6'd4,  32'h11);
      step(1'b1, 10'h340, 4'd14, 32'hA0, 32'h0, 32'h8,  6'd5,  32'h22);
      step(1'b1, 10'h200, 4'd7,  32'd3, 32'd5, 32'h0,   6'd6,  32'h33);
      // NEG 1, INC wrap
      step(1'b1, 10'h200, 4'd6,  32'd1, 32'h0, 32'h0,   6'd7,  32'h44);
      step(1'b1, 10'h200, 4'd5,  32'hFFFF_FFFF, 32'h0, 32'h0, 6'd8, 32'h55);
      // JM passthrough: dmem 0x40 arrives while JM is in EX
      step(1'b1, 10'h002, 4'd10, 32'h100, 32'h0, 32'h10, 6'd0, 32'h66);
      step(1'b1, 10'h000, 4'd0,  32'h0, 32'h0, 32'h0,   6'd0,  32'h40);
      step(1'b1, 10'h021, 4'd3,  32'h8, 32'h9, 32'h0,   6'd0,  32'h0);
      step(1'b1, 10'h000, 4'd0,  32'h0, 32'h0, 32'h0,   6'd0,  32'h0);

      for (int i = 0; i < 24; i++) rnd_step(1'b1);

      // reset mid-stream, then restart straight into traffic
      rnd_step(1'b0);
      for (int i = 0; i < 8; i++) rnd_step(1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
